calc_port_initiator: RTL and testbench

Synthesizable initiator for one calculator request/response port: the opposite end of the port the DUT wrapper exposes. Accepts operations on a valid/ready upstream interface, serializes them into the two-cycle request protocol with tags, tracks up to four outstanding tags, and matches out-of-order responses back to their commands. Used as a bus-functional model in the bench and as the front end for an on-chip traffic generator.

---
 rtl/calc_pkg.sv | 33 +++
 rtl/calc_tag_pool.sv | 85 ++++++++
 rtl/calc_port_initiator.sv | 186 ++++++++++++++++++
 tb/tb_calc_port_initiator.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and widths for the calculator request/response port.
package calc_pkg;

   localparam int TAG_W    = 2;
   localparam int DATA_W   = 32;
   localparam int CMD_W    = 4;
   localparam int NUM_TAGS = 1 << TAG_W;

   typedef enum logic [CMD_W-1:0] {
      CMD_NOP = 4'd0,
      CMD_ADD = 4'd1,
      CMD_SUB = 4'd2,
      CMD_SHL = 4'd5,
      CMD_SHR = 4'd6
   } cmd_e;

   typedef enum logic [1:0] {
      RESP_NONE = 2'd0,
      RESP_OK   = 2'd1,
      RESP_ERR  = 2'd2
   } resp_e;

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_DUT_ERR = 2'd1,
      ST_TIMEOUT = 2'd2
   } status_e;

   function automatic logic cmd_is_valid(input logic [CMD_W-1:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
   endfunction

endpackage

// File: rtl/calc_tag_pool.sv
// Tag table: busy bitmap, stored command and saturating age per tag,
// lowest-free allocation and lowest-expired timeout strobe.
module calc_tag_pool
   import calc_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alloc,
   input  logic [CMD_W-1:0] alloc_cmd,
   output logic [TAG_W-1:0] alloc_tag,
   output logic             can_alloc,
   input  logic [TAG_W-1:0] lookup_tag,
   output logic             lookup_busy,
   output logic [CMD_W-1:0] lookup_cmd,
   input  logic             release_lookup,
   output logic             timeout_valid,
   output logic [TAG_W-1:0] timeout_tag,
   output logic [CMD_W-1:0] timeout_cmd,
   input  logic             timeout_ack
);

   localparam int               AGE_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT_CYCLES - 1);
   localparam int               CNT_W    = TAG_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

   logic [NUM_TAGS-1:0] busy;
   logic [CMD_W-1:0]    cmd_q [NUM_TAGS];
   logic [AGE_W-1:0]    age_q [NUM_TAGS];
   logic [CNT_W-1:0]    busy_cnt;
   logic                free_any;

   // Priority-encode the lowest free and lowest expired tags; count occupancy
   always_comb begin
      alloc_tag     = '0;
      free_any      = 1'b0;
      timeout_tag   = '0;
      timeout_valid = 1'b0;
      busy_cnt      = '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
         if (!busy[i] && !free_any) begin
            free_any  = 1'b1;
            alloc_tag = TAG_W'(i);
         end
         if (busy[i] && (age_q[i] == AGE_LAST) && !timeout_valid) begin
            timeout_valid = 1'b1;
            timeout_tag   = TAG_W'(i);
         end
         busy_cnt = busy_cnt + CNT_W'(busy[i]);
      end
   end

   assign can_alloc   = free_any && (busy_cnt < CNT_MAX);
   assign lookup_busy = busy[lookup_tag];
   assign lookup_cmd  = cmd_q[lookup_tag];
   assign timeout_cmd = cmd_q[timeout_tag];

   // Per-tag allocate / release / age update; an expired age holds until acked
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= '0;
         for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            cmd_q[i] <= '0;
            age_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (alloc && (alloc_tag == TAG_W'(i))) begin
               busy[i]  <= 1'b1;
               cmd_q[i] <= alloc_cmd;
               age_q[i] <= '0;
            end else if ((release_lookup && (lookup_tag == TAG_W'(i))) ||
                         (timeout_ack && (timeout_tag == TAG_W'(i)))) begin
               busy[i] <= 1'b0;
            end else if (busy[i] && (age_q[i] != AGE_LAST)) begin
               age_q[i] <= age_q[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/calc_port_initiator.sv
// Initiator for the calculator port: accepts upstream operations, issues the
// two-cycle tagged request and reports one completion per cycle.
module calc_port_initiator
   import calc_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [CMD_W-1:0]  op_cmd,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [CMD_W-1:0]  req_cmd_in,
   output logic [DATA_W-1:0] req_data_in,
   output logic [TAG_W-1:0]  req_tag_in,
   input  logic [1:0]        out_resp,
   input  logic [DATA_W-1:0] out_data,
   input  logic [TAG_W-1:0]  out_tag,
   output logic              rsp_valid,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic [CMD_W-1:0]  rsp_cmd,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_status,
   output logic              spurious
);

   typedef enum logic {S_IDLE, S_OP2} state_e;

   state_e              state_q, state_n;
   logic                up_q;
   logic [DATA_W-1:0]   b_q;
   logic [CMD_W-1:0]    req_cmd_n;
   logic [DATA_W-1:0]   req_data_n;
   logic [TAG_W-1:0]    req_tag_n;

   logic                rej_pend_q, rej_pend_n;
   logic [CMD_W-1:0]    rej_cmd_q, rej_cmd_n;
   logic                rsp_valid_n, spurious_n;
   logic [TAG_W-1:0]    rsp_tag_n;
   logic [CMD_W-1:0]    rsp_cmd_n;
   logic [DATA_W-1:0]   rsp_data_n;
   logic [1:0]          rsp_status_n;

   logic                accept, acc_good, acc_bad, dut_done;
   logic [TAG_W-1:0]    alloc_tag;
   logic                can_alloc, lookup_busy, timeout_valid, timeout_ack;
   logic [CMD_W-1:0]    lookup_cmd, timeout_cmd;
   logic [TAG_W-1:0]    timeout_tag;

   calc_tag_pool #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
   ) u_pool (
      .clk            (clk),
      .reset          (reset),
      .alloc          (acc_good),
      .alloc_cmd      (op_cmd),
      .alloc_tag      (alloc_tag),
      .can_alloc      (can_alloc),
      .lookup_tag     (out_tag),
      .lookup_busy    (lookup_busy),
      .lookup_cmd     (lookup_cmd),
      .release_lookup (dut_done),
      .timeout_valid  (timeout_valid),
      .timeout_tag    (timeout_tag),
      .timeout_cmd    (timeout_cmd),
      .timeout_ack    (timeout_ack)
   );

   // A blocked reject holds op_ready low so at most one reject is ever queued
   assign op_ready   = (state_q == S_IDLE) && up_q && can_alloc && !rej_pend_q;
   assign accept     = op_valid && op_ready;
   assign acc_good   = accept && cmd_is_valid(op_cmd);
   assign acc_bad    = accept && !cmd_is_valid(op_cmd);
   assign dut_done   = ((out_resp == RESP_OK) || (out_resp == RESP_ERR)) && lookup_busy;
   assign spurious_n = (out_resp != RESP_NONE) && !dut_done;

   // Issue FSM next state and registered request bus values
   always_comb begin
      state_n    = state_q;
      req_cmd_n  = '0;
      req_data_n = '0;
      req_tag_n  = req_tag_in;
      case (state_q)
         S_IDLE: begin
            if (acc_good) begin
               state_n    = S_OP2;
               req_cmd_n  = op_cmd;
               req_data_n = op_a;
               req_tag_n  = alloc_tag;
            end
         end
         S_OP2: begin
            state_n    = S_IDLE;
            req_data_n = b_q;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Completion arbitration: DUT response, then reject, then timeout
   always_comb begin
      rsp_valid_n  = 1'b0;
      rsp_tag_n    = '0;
      rsp_cmd_n    = '0;
      rsp_data_n   = '0;
      rsp_status_n = ST_OK;
      rej_pend_n   = rej_pend_q;
      rej_cmd_n    = rej_cmd_q;
      timeout_ack  = 1'b0;
      if (dut_done) begin
         rsp_valid_n  = 1'b1;
         rsp_tag_n    = out_tag;
         rsp_cmd_n    = lookup_cmd;
         rsp_data_n   = out_data;
         rsp_status_n = (out_resp == RESP_OK) ? ST_OK : ST_DUT_ERR;
         if (acc_bad) begin
            rej_pend_n = 1'b1;
            rej_cmd_n  = op_cmd;
         end
      end else if (rej_pend_q) begin
         rsp_valid_n  = 1'b1;
         rsp_cmd_n    = rej_cmd_q;
         rsp_status_n = ST_DUT_ERR;
         rej_pend_n   = 1'b0;
      end else if (acc_bad) begin
         rsp_valid_n  = 1'b1;
         rsp_cmd_n    = op_cmd;
         rsp_status_n = ST_DUT_ERR;
      end else if (timeout_valid) begin
         rsp_valid_n  = 1'b1;
         rsp_tag_n    = timeout_tag;
         rsp_cmd_n    = timeout_cmd;
         rsp_status_n = ST_TIMEOUT;
         timeout_ack  = 1'b1;
      end
   end

   // FSM state, request bus and operand-2 holding registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         up_q        <= 1'b0;
         b_q         <= '0;
         req_cmd_in  <= '0;
         req_data_in <= '0;
         req_tag_in  <= '0;
      end else begin
         state_q     <= state_n;
         up_q        <= 1'b1;
         req_cmd_in  <= req_cmd_n;
         req_data_in <= req_data_n;
         req_tag_in  <= req_tag_n;
         if (acc_good) begin
            b_q <= op_b;
         end
      end
   end

   // Registered completion and spurious outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid  <= 1'b0;
         rsp_tag    <= '0;
         rsp_cmd    <= '0;
         rsp_data   <= '0;
         rsp_status <= '0;
         spurious   <= 1'b0;
         rej_pend_q <= 1'b0;
         rej_cmd_q  <= '0;
      end else begin
         rsp_valid  <= rsp_valid_n;
         rsp_tag    <= rsp_tag_n;
         rsp_cmd    <= rsp_cmd_n;
         rsp_data   <= rsp_data_n;
         rsp_status <= rsp_status_n;
         spurious   <= spurious_n;
         rej_pend_q <= rej_pend_n;
         rej_cmd_q  <= rej_cmd_n;
      end
   end

endmodule

// File: tb/tb_calc_port_initiator.sv
// Directed and randomized checks of calc_port_initiator against a tag-table
// model; a second instance with a short timeout covers retirement timing.
module tb_calc_port_initiator;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        reset;

   logic        op_valid, op_ready;
   logic [3:0]  op_cmd;
   logic [31:0] op_a, op_b;
   logic [3:0]  req_cmd_in;
   logic [31:0] req_data_in;
   logic [1:0]  req_tag_in;
   logic [1:0]  out_resp;
   logic [31:0] out_data;
   logic [1:0]  out_tag;
   logic        rsp_valid;
   logic [1:0]  rsp_tag;
   logic [3:0]  rsp_cmd;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_status;
   logic        spurious;

   logic        t_op_valid, t_op_ready;
   logic [3:0]  t_op_cmd;
   logic [31:0] t_op_a, t_op_b;
   logic [3:0]  t_req_cmd_in;
   logic [31:0] t_req_data_in;
   logic [1:0]  t_req_tag_in;
   logic [1:0]  t_out_resp;
   logic [31:0] t_out_data;
   logic [1:0]  t_out_tag;
   logic        t_rsp_valid;
   logic [1:0]  t_rsp_tag;
   logic [3:0]  t_rsp_cmd;
   logic [31:0] t_rsp_data;
   logic [1:0]  t_rsp_status;
   logic        t_spurious;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   logic        m_busy [4];
   logic [3:0]  m_cmd  [4];
   logic [31:0] m_a    [4];
   logic [31:0] m_b    [4];
   logic [3:0]  cmd_tab [4] = '{4'd1, 4'd2, 4'd5, 4'd6};

   calc_port_initiator dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
      .op_cmd(op_cmd), .op_a(op_a), .op_b(op_b),
      .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
      .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_cmd(rsp_cmd),
      .rsp_data(rsp_data), .rsp_status(rsp_status), .spurious(spurious)
   );

   calc_port_initiator #(.MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(TMO)) dut_tmo (
      .clk(clk), .reset(reset), .op_valid(t_op_valid), .op_ready(t_op_ready),
      .op_cmd(t_op_cmd), .op_a(t_op_a), .op_b(t_op_b),
      .req_cmd_in(t_req_cmd_in), .req_data_in(t_req_data_in), .req_tag_in(t_req_tag_in),
      .out_resp(t_out_resp), .out_data(t_out_data), .out_tag(t_out_tag),
      .rsp_valid(t_rsp_valid), .rsp_tag(t_rsp_tag), .rsp_cmd(t_rsp_cmd),
      .rsp_data(t_rsp_data), .rsp_status(t_rsp_status), .spurious(t_spurious)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // What an ideal calculator returns for an operation
   function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         4'd1:    return a + b;
         4'd2:    return a - b;
         4'd5:    return a << b[4:0];
         4'd6:    return a >> b[4:0];
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [1:0] ref_resp(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (c == 4'd1 && s[32]) return 2'd2;
      if (c == 4'd2 && b > a) return 2'd2;
      return 2'd1;
   endfunction

   function automatic int lowest_free();
      for (int i = 0; i < 4; i++) if (!m_busy[i]) return i;
      return -1;
   endfunction

   task automatic wait_ready();
      for (int k = 0; k < 16 && !op_ready; k++) @(negedge clk);
      chk("op_ready_wait", op_ready, 1);
   endtask

   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      int t;
      wait_ready();
      t = lowest_free();
      op_valid = 1'b1; op_cmd = c; op_a = a; op_b = b;
      @(negedge clk);
      op_valid = 1'b0;
      chk("req_cmd", req_cmd_in, c);
      chk("req_data_a", req_data_in, a);
      chk("req_tag", req_tag_in, t[1:0]);
      if (t >= 0) begin
         m_busy[t] = 1'b1; m_cmd[t] = c; m_a[t] = a; m_b[t] = b;
      end
      @(negedge clk);
      chk("req_nop", req_cmd_in, 0);
      chk("req_data_b", req_data_in, b);
   endtask

   task automatic respond(input logic [1:0] r, input logic [1:0] t, input logic [31:0] d);
      logic hit;
      hit = m_busy[t] && (r == 2'd1 || r == 2'd2);
      out_resp = r; out_tag = t; out_data = d;
      @(negedge clk);
      out_resp = 2'd0; out_tag = 2'd0; out_data = 32'd0;
      chk("rsp_valid", rsp_valid, hit);
      chk("spurious", spurious, !hit);
      if (hit) begin
         chk("rsp_tag", rsp_tag, t);
         chk("rsp_cmd", rsp_cmd, m_cmd[t]);
         chk("rsp_data", rsp_data, d);
         chk("rsp_status", rsp_status, (r == 2'd1) ? 32'd0 : 32'd1);
         m_busy[t] = 1'b0;
      end
   endtask

   task automatic reply(input logic [1:0] t);
      respond(ref_resp(m_cmd[t], m_a[t], m_b[t]), t, ref_result(m_cmd[t], m_a[t], m_b[t]));
   endtask

   task automatic t_issue(input logic [3:0] c, input logic [1:0] exp_tag, output int rq);
      for (int k = 0; k < 16 && !t_op_ready; k++) @(negedge clk);
      chk("t_op_ready_wait", t_op_ready, 1);
      t_op_valid = 1'b1; t_op_cmd = c; t_op_a = 32'd3; t_op_b = 32'd4;
      @(negedge clk);
      t_op_valid = 1'b0;
      rq = cyc;
      chk("t_req_cmd", t_req_cmd_in, c);
      chk("t_req_tag", t_req_tag_in, exp_tag);
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, r1, seen, n, idx;
      int q[$];
      logic [31:0] a;

      for (int i = 0; i < 4; i++) begin
         m_busy[i] = 1'b0; m_cmd[i] = '0; m_a[i] = '0; m_b[i] = '0;
      end
      reset = 1'b1;
      op_valid = 0; op_cmd = 0; op_a = 0; op_b = 0;
      out_resp = 0; out_data = 0; out_tag = 0;
      t_op_valid = 0; t_op_cmd = 0; t_op_a = 0; t_op_b = 0;
      t_out_resp = 0; t_out_data = 0; t_out_tag = 0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_op_ready", op_ready, 0);
      chk("rst_req_cmd", req_cmd_in, 0);
      chk("rst_req_data", req_data_in, 0);
      chk("rst_req_tag", req_tag_in, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_spurious", spurious, 0);
      chk("rst_t_op_ready", t_op_ready, 0);
      reset = 1'b0;

      // single add answered four cycles after the request
      issue(4'd1, 32'd5, 32'd7);
      repeat (3) @(negedge clk);
      respond(2'd1, 2'd0, 32'd12);
      @(negedge clk);
      chk("rsp_pulse_single", rsp_valid, 0);

      // fill all four tags, free tag 2, reuse it
      issue(4'd1, 32'd10, 32'd20);
      issue(4'd2, 32'd50, 32'd8);
      issue(4'd5, 32'd3, 32'd4);
      issue(4'd6, 32'd256, 32'd2);
      chk("full_op_ready", op_ready, 0);
      reply(2'd2);
      chk("ready_after_free", op_ready, 1);
      issue(4'd1, 32'd100, 32'd200);

      // out-of-order responses in consecutive cycles
      reply(2'd3);
      reply(2'd0);
      reply(2'd1);
      reply(2'd2);

      // invalid command: immediate error pulse, no tag consumed
      wait_ready();
      op_valid = 1'b1; op_cmd = 4'd3; op_a = 32'd1; op_b = 32'd1;
      @(negedge clk);
      op_valid = 1'b0;
      chk("inv_rsp_valid", rsp_valid, 1);
      chk("inv_rsp_status", rsp_status, 1);
      chk("inv_rsp_tag", rsp_tag, 0);
      chk("inv_rsp_data", rsp_data, 0);
      chk("inv_req_cmd", req_cmd_in, 0);
      chk("inv_op_ready", op_ready, 1);

      // overflow, preceded by a reserved response code on the busy tag
      issue(4'd1, 32'hFFFF_FFFF, 32'd1);
      respond(2'd3, 2'd0, 32'd0);
      respond(2'd2, 2'd0, 32'd0);
      respond(2'd1, 2'd1, 32'h1234);

      // reset while three are outstanding and the third is mid-issue
      issue(4'd2, 32'd9, 32'd4);
      issue(4'd5, 32'd1, 32'd3);
      wait_ready();
      op_valid = 1'b1; op_cmd = 4'd6; op_a = 32'd77; op_b = 32'd88;
      @(negedge clk);
      op_valid = 1'b0;
      chk("op2_req_cmd", req_cmd_in, 6);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_req_cmd", req_cmd_in, 0);
      chk("abort_req_data", req_data_in, 0);
      chk("abort_op_ready", op_ready, 0);
      chk("abort_rsp_valid", rsp_valid, 0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) m_busy[i] = 1'b0;
      wait_ready();
      respond(2'd1, 2'd1, 32'd5);
      issue(4'd1, 32'd1, 32'd1);
      reply(2'd0);

      // randomized batches drained in random order
      for (int it = 0; it < 40; it++) begin
         n = $urandom_range(1, 3);
         for (int j = 0; j < n; j++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFF;
            issue(cmd_tab[$urandom_range(0, 3)], a, $urandom);
         end
         q.delete();
         for (int i = 0; i < 4; i++) if (m_busy[i]) q.push_back(i);
         while (q.size() > 0) begin
            idx = $urandom_range(0, q.size() - 1);
            reply(2'(q[idx]));
            q.delete(idx);
         end
         respond(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // timeout exactly TMO cycles after the request, late answer is spurious
      t_issue(4'd1, 2'd0, r0);
      seen = cyc;
      for (int k = 0; k < 20 && !t_rsp_valid; k++) begin
         @(negedge clk);
         seen = cyc;
      end
      chk("tmo_latency", seen - r0, TMO);
      chk("tmo_status", t_rsp_status, 2);
      chk("tmo_tag", t_rsp_tag, 0);
      chk("tmo_cmd", t_rsp_cmd, 1);
      chk("tmo_data", t_rsp_data, 0);
      t_out_resp = 2'd1; t_out_tag = 2'd0; t_out_data = 32'd7;
      @(negedge clk);
      t_out_resp = 2'd0;
      chk("tmo_late_spurious", t_spurious, 1);
      chk("tmo_late_rsp_valid", t_rsp_valid, 0);

      // DUT completion in the expiry cycle of another tag defers the timeout
      t_issue(4'd2, 2'd0, r0);
      t_issue(4'd5, 2'd1, r1);
      while (cyc < r0 + TMO - 1) @(negedge clk);
      t_out_resp = 2'd1; t_out_tag = 2'd1; t_out_data = 32'd77;
      @(negedge clk);
      t_out_resp = 2'd0;
      chk("defer_dut_valid", t_rsp_valid, 1);
      chk("defer_dut_tag", t_rsp_tag, 1);
      chk("defer_dut_cmd", t_rsp_cmd, 5);
      chk("defer_dut_status", t_rsp_status, 0);
      chk("defer_dut_data", t_rsp_data, 77);
      @(negedge clk);
      chk("defer_tmo_valid", t_rsp_valid, 1);
      chk("defer_tmo_tag", t_rsp_tag, 0);
      chk("defer_tmo_cmd", t_rsp_cmd, 2);
      chk("defer_tmo_status", t_rsp_status, 2);
      chk("defer_tmo_when", cyc - r0, TMO + 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
